// File: rtl/tlc_pkg.sv
// Shared types and default timing for the intersection phase scheduler.
package tlc_pkg;

  typedef enum logic [1:0] {
    ALL_RED,
    GREEN,
    YELLOW
  } tlc_state_e;

  localparam int DEF_N_APPR      = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_T_MIN_GREEN = 10;
  localparam int DEF_T_MAX_GREEN = 30;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALL_RED   = 2;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin selector: first pending approach after 'last', wrapping, 'last' itself lowest.
module tlc_rr_pick
  import tlc_pkg::*;
#(
  parameter int N_APPR = DEF_N_APPR
) (
  input  logic [N_APPR-1:0]                pend,
  input  logic [idx_width(N_APPR)-1:0]     last,
  output logic [idx_width(N_APPR)-1:0]     idx,
  output logic                             valid
);

  localparam int AW = idx_width(N_APPR);

  logic [AW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_APPR; k++) begin
      cand = AW'((int'(last) + k) % N_APPR);
      if (!valid && pend[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Shares one green phase among N_APPR approaches with latched demand, round-robin
// grants and min/max green, yellow and all-red clearance timing.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int N_APPR       = DEF_N_APPR,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int T_MIN_GREEN  = DEF_T_MIN_GREEN,
  parameter int T_MAX_GREEN  = DEF_T_MAX_GREEN,
  parameter int T_YELLOW     = DEF_T_YELLOW,
  parameter int T_ALL_RED    = DEF_T_ALL_RED,
  parameter int DEFAULT_APPR = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [N_APPR-1:0]             req,
  output logic [N_APPR-1:0]             red,
  output logic [N_APPR-1:0]             yellow,
  output logic [N_APPR-1:0]             green,
  output logic [idx_width(N_APPR)-1:0]  active,
  output logic                          grant
);

  localparam int AW = idx_width(N_APPR);
  localparam logic [N_APPR-1:0] ONE = N_APPR'(1);

  tlc_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    cnt_inc;
  logic [N_APPR-1:0] pend;
  logic [N_APPR-1:0] pend_set;
  logic [N_APPR-1:0] act_mask;
  logic [N_APPR-1:0] next_mask;
  logic [AW-1:0]     rr_idx;
  logic [AW-1:0]     next_appr;
  logic              rr_valid;
  logic              other;
  logic              green_exit;

  tlc_rr_pick #(
    .N_APPR (N_APPR)
  ) u_rr_pick (
    .pend  (pend),
    .last  (active),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  assign next_appr = rr_valid ? rr_idx : AW'(DEFAULT_APPR);
  assign act_mask  = ONE << active;
  assign next_mask = ONE << next_appr;
  assign pend_set  = pend | req;
  assign other     = |(pend & ~act_mask);
  assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);

  // Leave green only if someone else waits: gap-out after min green, or max-out.
  assign green_exit = other &&
                      (((cnt_inc >= (CNT_W+1)'(T_MIN_GREEN)) && !pend[active]) ||
                       (cnt_inc >= (CNT_W+1)'(T_MAX_GREEN)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ALL_RED;
      cnt    <= '0;
      pend   <= '0;
      active <= AW'(DEFAULT_APPR);
      red    <= '1;
      yellow <= '0;
      green  <= '0;
      grant  <= 1'b0;
    end else begin
      grant <= 1'b0;
      pend  <= pend_set;
      if (tick) begin
        cnt <= (cnt == CNT_W'(T_MAX_GREEN)) ? cnt : cnt_inc[CNT_W-1:0];
        unique case (state)
          ALL_RED: begin
            if (cnt == CNT_W'(T_ALL_RED - 1)) begin
              state  <= GREEN;
              cnt    <= '0;
              active <= next_appr;
              grant  <= 1'b1;
              pend   <= pend_set & ~next_mask;
              red    <= ~next_mask;
              yellow <= '0;
              green  <= next_mask;
            end
          end
          GREEN: begin
            if (green_exit) begin
              state  <= YELLOW;
              cnt    <= '0;
              red    <= ~act_mask;
              yellow <= act_mask;
              green  <= '0;
            end
          end
          YELLOW: begin
            if (cnt == CNT_W'(T_YELLOW - 1)) begin
              state  <= ALL_RED;
              cnt    <= '0;
              red    <= '1;
              yellow <= '0;
              green  <= '0;
            end
          end
          default: begin
            state  <= ALL_RED;
            cnt    <= '0;
            red    <= '1;
            yellow <= '0;
            green  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Scenario bench for tlc_phase_scheduler; expected grants go through a scoreboard queue
// popped by a lamp/grant monitor on the falling edge.
module tb_tlc_phase_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [N-1:0] req;
  logic [N-1:0] red;
  logic [N-1:0] yellow;
  logic [N-1:0] green;
  logic [1:0]   active;
  logic         grant;

  int checks = 0;
  int errors = 0;
  int sb_q[$];
  int sb_exp;
  logic [N-1:0] lamp_bad;

  tlc_phase_scheduler #(
    .N_APPR       (4),
    .CNT_W        (8),
    .T_MIN_GREEN  (10),
    .T_MAX_GREEN  (30),
    .T_YELLOW     (3),
    .T_ALL_RED    (2),
    .DEFAULT_APPR (0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .req    (req),
    .red    (red),
    .yellow (yellow),
    .green  (green),
    .active (active),
    .grant  (grant)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One lamp per approach, only the active approach off red; grants checked against the queue.
  always @(negedge clk) begin
    lamp_bad = (red & yellow) | (red & green) | (yellow & green) |
               ~(red | yellow | green) | (~red & ~(4'b0001 << active));
    checks++;
    if (lamp_bad !== '0) begin
      errors++;
      $display("[TB] FAIL lamp_invariant: red=%b yellow=%b green=%b active=%0d", red, yellow, green, active);
    end
    if (grant === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_grant: got active=%0d, no grant expected", active);
      end else begin
        sb_exp = sb_q.pop_front();
        if (int'(active) !== sb_exp) begin
          errors++;
          $display("[TB] FAIL grant_order: got active=%0d, expected %0d", active, sb_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; tick = 1'b1; req = '0;
    step(3);
    checks++; if (red !== 4'hF) begin errors++; $display("[TB] FAIL reset_red: got %b, expected 1111", red); end
    checks++; if (yellow !== 4'h0) begin errors++; $display("[TB] FAIL reset_yellow: got %b, expected 0000", yellow); end
    checks++; if (green !== 4'h0) begin errors++; $display("[TB] FAIL reset_green: got %b, expected 0000", green); end
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %b, expected 0", grant); end
    checks++; if (active !== 2'd0) begin errors++; $display("[TB] FAIL reset_active: got %0d, expected 0", active); end
    sb_q.push_back(0);
    rst = 1'b1;
    step(1);
    checks++; if (green !== 4'h0) begin errors++; $display("[TB] FAIL release_clear: got green=%b, expected 0000", green); end
    step(1);
    checks++; if (green !== 4'b0001) begin errors++; $display("[TB] FAIL release_green: got %b, expected 0001", green); end
    checks++; if (grant !== 1'b1) begin errors++; $display("[TB] FAIL release_grant: got %b, expected 1", grant); end
    checks++; if (active !== 2'd0) begin errors++; $display("[TB] FAIL release_active: got %0d, expected 0", active); end
    step(1);
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL grant_pulse: got %b, expected 0", grant); end
  endtask

  task automatic test_gap_out();
    int n;
    req = 4'b0100;
    sb_q.push_back(2);
    step(1);
    req = '0;
    n = 2;
    while (green[0] === 1'b1 && n < 200) begin step(1); n++; end
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL gap_green_len: got %0d, expected 10", n); end
    checks++; if (yellow !== 4'b0001) begin errors++; $display("[TB] FAIL gap_yellow: got %b, expected 0001", yellow); end
    n = 0;
    while (yellow[0] === 1'b1 && n < 50) begin step(1); n++; end
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL gap_yellow_len: got %0d, expected 3", n); end
    checks++; if (red !== 4'hF) begin errors++; $display("[TB] FAIL gap_all_red: got %b, expected 1111", red); end
    n = 0;
    while (green === 4'b0000 && n < 50) begin step(1); n++; end
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL gap_all_red_len: got %0d, expected 2", n); end
    checks++; if (green !== 4'b0100) begin errors++; $display("[TB] FAIL gap_next_green: got %b, expected 0100", green); end
    checks++; if (grant !== 1'b1) begin errors++; $display("[TB] FAIL gap_grant: got %b, expected 1", grant); end
  endtask

  task automatic test_max_out();
    int n;
    req = 4'b0011;
    sb_q.push_back(0);
    sb_q.push_back(1);
    n = 0;
    while (green !== 4'b0001 && n < 100) begin step(1); n++; end
    checks++; if (green !== 4'b0001) begin errors++; $display("[TB] FAIL max_reach_green0: got %b, expected 0001", green); end
    n = 0;
    while (green[0] === 1'b1 && n < 100) begin step(1); n++; end
    checks++; if (n != 30) begin errors++; $display("[TB] FAIL max_green_len: got %0d, expected 30", n); end
    checks++; if (yellow !== 4'b0001) begin errors++; $display("[TB] FAIL max_yellow: got %b, expected 0001", yellow); end
    req = '0;
    n = 0;
    while (green !== 4'b0010 && n < 50) begin step(1); n++; end
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL max_to_green1: got %0d ticks, expected 5", n); end
    checks++; if (active !== 2'd1) begin errors++; $display("[TB] FAIL max_active: got %0d, expected 1", active); end
  endtask

  task automatic test_round_robin();
    int n;
    int got;
    int order[3];
    req = 4'b1101;
    sb_q.push_back(2);
    sb_q.push_back(3);
    sb_q.push_back(0);
    step(1);
    req = '0;
    n = 0;
    got = 0;
    order = '{-1, -1, -1};
    while (got < 3 && n < 200) begin
      step(1);
      n++;
      if (grant === 1'b1) begin order[got] = int'(active); got++; end
    end
    checks++; if (got != 3) begin errors++; $display("[TB] FAIL rr_grant_count: got %0d, expected 3", got); end
    checks++; if (order[0] != 2) begin errors++; $display("[TB] FAIL rr_first: got %0d, expected 2", order[0]); end
    checks++; if (order[1] != 3) begin errors++; $display("[TB] FAIL rr_second: got %0d, expected 3", order[1]); end
    checks++; if (order[2] != 0) begin errors++; $display("[TB] FAIL rr_third: got %0d, expected 0", order[2]); end
  endtask

  task automatic test_dwell_and_tick();
    int n;
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (green !== 4'b0001 || grant !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL dwell: got %0d bad cycles, expected 0", bad); end
    req = 4'b0010;
    sb_q.push_back(1);
    step(1);
    req = '0;
    n = 0;
    while (yellow !== 4'b0001 && n < 20) begin step(1); n++; end
    checks++; if (yellow !== 4'b0001) begin errors++; $display("[TB] FAIL dwell_exit: got yellow=%b, expected 0001", yellow); end
    tick = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (yellow !== 4'b0001 || red !== 4'b1110) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL tick_freeze: got %0d moved cycles, expected 0", bad); end
    tick = 1'b1;
    n = 0;
    while (yellow[0] === 1'b1 && n < 50) begin step(1); n++; end
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL resume_yellow_len: got %0d, expected 3", n); end
    n = 0;
    while (green !== 4'b0010 && n < 50) begin step(1); n++; end
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL resume_all_red_len: got %0d, expected 2", n); end
  endtask

  task automatic test_reset_mid_yellow();
    int n;
    int bad;
    req = 4'b1010;
    step(1);
    req = '0;
    n = 0;
    while (yellow !== 4'b0010 && n < 60) begin step(1); n++; end
    checks++; if (yellow !== 4'b0010) begin errors++; $display("[TB] FAIL mid_reach_yellow: got %b, expected 0010", yellow); end
    rst = 1'b0;
    #1;
    checks++; if (red !== 4'hF) begin errors++; $display("[TB] FAIL mid_reset_red: got %b, expected 1111", red); end
    checks++; if (yellow !== 4'h0) begin errors++; $display("[TB] FAIL mid_reset_yellow: got %b, expected 0000", yellow); end
    checks++; if (active !== 2'd0) begin errors++; $display("[TB] FAIL mid_reset_active: got %0d, expected 0", active); end
    step(2);
    sb_q.push_back(0);
    rst = 1'b1;
    n = 0;
    while (green !== 4'b0001 && n < 10) begin step(1); n++; end
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL mid_release_len: got %0d, expected 2", n); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (green !== 4'b0001 || grant !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL pend_discarded: got %0d bad cycles, expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_gap_out();
    test_max_out();
    test_round_robin();
    test_dwell_and_tick();
    test_reset_mid_yellow();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL grants_outstanding: got %0d left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
